// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-extension pipe: format select encoding
// and the default immediate width.
package imm_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100,
    IMM_Z = 3'b101
  } imm_src_e;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Valid/ready bus for imm_ext_pipe: instruction input side and extended
// immediate output side. The slave modport is the pipe itself; the master
// modport is its environment (upstream producer plus downstream consumer).
interface imm_ext_pipe_if import imm_pkg::*; #(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned TAG_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, in_instr, in_imm_src, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decode: selects the immediate fields of the
// instruction by format and sign-extends the result to XLEN.
// Optional feature: define IMM_EXT_ZICSR_EN to make encoding 101 (Z-type,
// zero-extended rs1 field) legal; otherwise 101 decodes as illegal.
module imm_decode import imm_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr_i,
  input  imm_src_e        imm_src_i,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  logic [31:0] imm32;

  // Build a 32-bit immediate per format; illegal formats yield zero.
  always_comb begin
    imm32     = '0;
    illegal_o = 1'b0;
    case (imm_src_i)
      IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
      IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
      IMM_U: imm32 = {instr_i[31:12], 12'b0};
`ifdef IMM_EXT_ZICSR_EN
      // Bit 31 is zero, so the common sign extension below zero-extends.
      IMM_Z: imm32 = {27'b0, instr_i[19:15]};
`endif
      default: illegal_o = 1'b1;
    endcase
  end

  // Every format's top bit sits at bit 31 of imm32, so one extension suffices.
  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate-extension pipe stage: decodes the immediate ahead of a two-entry
// skid buffer (output register plus skid register) so in_ready is registered.
// Optional feature: IMM_EXT_ZICSR_EN enables Z-type decode in imm_decode.
module imm_ext_pipe import imm_pkg::*; #(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned TAG_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  imm_ext_pipe_if.slave bus,
  output logic [15:0]  err_count
);

  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;

  logic             out_valid_d, out_valid_q;
  logic [XLEN-1:0]  out_imm_d, out_imm_q;
  logic [TAG_W-1:0] out_tag_d, out_tag_q;
  logic             out_illegal_d, out_illegal_q;
  logic             skid_valid_d, skid_valid_q;
  logic [XLEN-1:0]  skid_imm_d, skid_imm_q;
  logic [TAG_W-1:0] skid_tag_d, skid_tag_q;
  logic             skid_illegal_d, skid_illegal_q;
  logic [15:0]      err_count_d, err_count_q;

  logic accept;
  logic out_free;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr_i   (bus.in_instr),
    .imm_src_i (imm_src_e'(bus.in_imm_src)),
    .imm_o     (dec_imm),
    .illegal_o (dec_illegal)
  );

  // Flush wins over any same-cycle input.
  assign accept   = bus.in_valid && !skid_valid_q && !flush;
  // Output register can take a new entry when empty or draining this edge.
  assign out_free = !out_valid_q || bus.out_ready;

  // Next-state for output/skid registers and the illegal-entry counter.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_imm_d      = out_imm_q;
    out_tag_d      = out_tag_q;
    out_illegal_d  = out_illegal_q;
    skid_valid_d   = skid_valid_q;
    skid_imm_d     = skid_imm_q;
    skid_tag_d     = skid_tag_q;
    skid_illegal_d = skid_illegal_q;
    err_count_d    = err_count_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        // Skid full implies in_ready low, so no input competes here.
        out_valid_d   = 1'b1;
        out_imm_d     = skid_imm_q;
        out_tag_d     = skid_tag_q;
        out_illegal_d = skid_illegal_q;
        skid_valid_d  = 1'b0;
      end else if (accept) begin
        out_valid_d   = 1'b1;
        out_imm_d     = dec_imm;
        out_tag_d     = bus.in_tag;
        out_illegal_d = dec_illegal;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d   = 1'b1;
      skid_imm_d     = dec_imm;
      skid_tag_d     = bus.in_tag;
      skid_illegal_d = dec_illegal;
    end

    if (accept && dec_illegal && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_imm_q      <= '0;
      out_tag_q      <= '0;
      out_illegal_q  <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_imm_q     <= '0;
      skid_tag_q     <= '0;
      skid_illegal_q <= 1'b0;
      err_count_q    <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_imm_q      <= out_imm_d;
      out_tag_q      <= out_tag_d;
      out_illegal_q  <= out_illegal_d;
      skid_valid_q   <= skid_valid_d;
      skid_imm_q     <= skid_imm_d;
      skid_tag_q     <= skid_tag_d;
      skid_illegal_q <= skid_illegal_d;
      err_count_q    <= err_count_d;
    end
  end

  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_tag     = out_tag_q;
  assign bus.out_illegal = out_illegal_q;
  assign err_count       = err_count_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed self-checking bench for imm_ext_pipe (XLEN=32 and XLEN=64 instances).
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [15:0] err32, err64;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  imm_ext_pipe_if #(.XLEN(32), .TAG_W(5)) bus32 ();
  imm_ext_pipe_if #(.XLEN(64), .TAG_W(5)) bus64 ();

  imm_ext_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus32.slave),
    .err_count (err32)
  );

  imm_ext_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus64.slave),
    .err_count (err64)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, input logic [31:0] instr, input logic [2:0] src,
                         input logic [4:0] tag);
    bus32.in_valid   = v;
    bus32.in_instr   = instr;
    bus32.in_imm_src = src;
    bus32.in_tag     = tag;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
    bus32.out_ready  = 1'b1;
    bus64.in_valid   = 1'b0;
    bus64.in_instr   = 32'h0;
    bus64.in_imm_src = 3'b000;
    bus64.in_tag     = 5'd0;
    bus64.out_ready  = 1'b1;
    #2;
    n_checks++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 || bus32.out_imm !== 32'h0 ||
        bus32.out_tag !== 5'd0 || bus32.out_illegal !== 1'b0 || err32 !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: v=%b rdy=%b imm=%h tag=%0d ill=%b err=%0d want 0 1 0 0 0 0",
               bus32.out_valid, bus32.in_ready, bus32.out_imm, bus32.out_tag,
               bus32.out_illegal, err32);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  // One entry per format with out_ready high; each appears one cycle later.
  task automatic test_formats();
    logic [31:0] instrs [5] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'hFF9FF06F,
                                32'h12345037};
    logic [2:0]  srcs   [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    logic [31:0] exps   [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFF8,
                                32'h12345000};
    for (int i = 0; i < 5; i++) begin
      drive32(1'b1, instrs[i], srcs[i], 5'(i + 1));
      step();
      drive32(1'b0, 32'h0, 3'b000, 5'd0);
      n_checks++;
      if (bus32.out_valid !== 1'b1 || bus32.out_imm !== exps[i] ||
          bus32.out_illegal !== 1'b0 || bus32.out_tag !== 5'(i + 1)) begin
        n_fail++;
        $display("FAIL format_%0d: v=%b imm=%h ill=%b tag=%0d want 1 %h 0 %0d", i,
                 bus32.out_valid, bus32.out_imm, bus32.out_illegal, bus32.out_tag,
                 exps[i], i + 1);
      end
      step();
      n_checks++;
      if (bus32.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL format_drain_%0d: out_valid=%b want 0", i, bus32.out_valid);
      end
    end
  endtask

  task automatic test_xlen64();
    logic [31:0] instrs [2] = '{32'h80000037, 32'h7FF00093};
    logic [2:0]  srcs   [2] = '{3'b100, 3'b000};
    logic [63:0] exps   [2] = '{64'hFFFFFFFF80000000, 64'h00000000000007FF};
    for (int i = 0; i < 2; i++) begin
      bus64.in_valid   = 1'b1;
      bus64.in_instr   = instrs[i];
      bus64.in_imm_src = srcs[i];
      step();
      bus64.in_valid = 1'b0;
      n_checks++;
      if (bus64.out_valid !== 1'b1 || bus64.out_imm !== exps[i] || bus64.out_illegal !== 1'b0)
      begin
        n_fail++;
        $display("FAIL xlen64_%0d: v=%b imm=%h ill=%b want 1 %h 0", i, bus64.out_valid,
                 bus64.out_imm, bus64.out_illegal, exps[i]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    bus32.out_ready = 1'b0;
    drive32(1'b1, 32'h00100093, 3'b000, 5'd1);
    step();
    drive32(1'b1, 32'h00200093, 3'b000, 5'd2);
    n_checks++;
    if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 5'd1 || bus32.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first: v=%b tag=%0d rdy=%b want 1 1 1", bus32.out_valid,
               bus32.out_tag, bus32.in_ready);
    end
    step();
    drive32(1'b1, 32'h00300093, 3'b000, 5'd3);
    n_checks++;
    if (bus32.in_ready !== 1'b0 || bus32.out_tag !== 5'd1 || bus32.out_imm !== 32'd1) begin
      n_fail++;
      $display("FAIL bp_skid_full: rdy=%b tag=%0d imm=%h want 0 1 1", bus32.in_ready,
               bus32.out_tag, bus32.out_imm);
    end
    step();
    n_checks++;
    if (bus32.in_ready !== 1'b0 || bus32.out_tag !== 5'd1 || bus32.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: rdy=%b tag=%0d v=%b want 0 1 1", bus32.in_ready,
               bus32.out_tag, bus32.out_valid);
    end
    bus32.out_ready = 1'b1;
    step();
    n_checks++;
    if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 5'd2 || bus32.out_imm !== 32'd2 ||
        bus32.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: v=%b tag=%0d imm=%h rdy=%b want 1 2 2 1", bus32.out_valid,
               bus32.out_tag, bus32.out_imm, bus32.in_ready);
    end
    step();
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
    n_checks++;
    if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 5'd3 || bus32.out_imm !== 32'd3) begin
      n_fail++;
      $display("FAIL bp_third: v=%b tag=%0d imm=%h want 1 3 3", bus32.out_valid,
               bus32.out_tag, bus32.out_imm);
    end
    step();
    n_checks++;
    if (bus32.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: out_valid=%b want 0 (duplicate)", bus32.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive32(1'b1, {12'(10 + i), 20'h00093}, 3'b000, 5'(10 + i));
      step();
      n_checks++;
      if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 5'(10 + i) ||
          bus32.out_imm !== 32'(10 + i) || bus32.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_%0d: v=%b tag=%0d imm=%h rdy=%b want 1 %0d %h 1", i,
                 bus32.out_valid, bus32.out_tag, bus32.out_imm, bus32.in_ready, 10 + i,
                 10 + i);
      end
    end
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
    step();
  endtask

  task automatic test_illegal();
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive32(1'b1, 32'hFFFFFFFF, 3'b111, 5'd20);
      step();
      drive32(1'b0, 32'h0, 3'b000, 5'd0);
      n_checks++;
      if (bus32.out_valid !== 1'b1 || bus32.out_imm !== 32'h0 || bus32.out_illegal !== 1'b1)
      begin
        n_fail++;
        $display("FAIL illegal_111_%0d: v=%b imm=%h ill=%b want 1 0 1", i, bus32.out_valid,
                 bus32.out_imm, bus32.out_illegal);
      end
    end
    n_checks++;
    if (err32 !== 16'd2) begin
      n_fail++;
      $display("FAIL err_count_two: got %0d want 2", err32);
    end
    drive32(1'b1, 32'h000F8073, 3'b101, 5'd21);
    step();
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
`ifndef IMM_EXT_ZICSR_EN
    n_checks++;
    if (bus32.out_illegal !== 1'b1 || bus32.out_imm !== 32'h0 || err32 !== 16'd3) begin
      n_fail++;
      $display("FAIL illegal_101: ill=%b imm=%h err=%0d want 1 0 3", bus32.out_illegal,
               bus32.out_imm, err32);
    end
`else
    n_checks++;
    if (bus32.out_illegal !== 1'b0 || bus32.out_imm !== 32'h1F || err32 !== 16'd2) begin
      n_fail++;
      $display("FAIL zicsr_101: ill=%b imm=%h err=%0d want 0 1f 2", bus32.out_illegal,
               bus32.out_imm, err32);
    end
`endif
    step();
  endtask

  task automatic test_flush();
    logic [15:0] err_before;
    err_before = err32;
    bus32.out_ready = 1'b0;
    drive32(1'b1, 32'h00400093, 3'b000, 5'd4);
    step();
    drive32(1'b1, 32'h00500093, 3'b000, 5'd5);
    step();
    // Both entries held; flush with an illegal input pending.
    drive32(1'b1, 32'hFFFFFFFF, 3'b111, 5'd6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
    n_checks++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 || err32 !== err_before) begin
      n_fail++;
      $display("FAIL flush_full: v=%b rdy=%b err=%0d want 0 1 %0d", bus32.out_valid,
               bus32.in_ready, err32, err_before);
    end
    // Flush while empty and ready: the same-cycle input must be dropped.
    bus32.out_ready = 1'b1;
    drive32(1'b1, 32'hFFFFFFFF, 3'b110, 5'd7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
    n_checks++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 || err32 !== err_before) begin
      n_fail++;
      $display("FAIL flush_empty: v=%b rdy=%b err=%0d want 0 1 %0d", bus32.out_valid,
               bus32.in_ready, err32, err_before);
    end
    step();
    n_checks++;
    if (bus32.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_emit: out_valid=%b want 0", bus32.out_valid);
    end
  endtask

  task automatic test_async_reset();
    bus32.out_ready = 1'b0;
    drive32(1'b1, 32'hFFF00093, 3'b000, 5'd8);
    step();
    drive32(1'b1, 32'hFFFFFFFF, 3'b111, 5'd9);
    step();
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 || bus32.out_imm !== 32'h0 ||
        bus32.out_tag !== 5'd0 || bus32.out_illegal !== 1'b0 || err32 !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: v=%b rdy=%b imm=%h tag=%0d ill=%b err=%0d want 0 1 0 0 0 0",
               bus32.out_valid, bus32.in_ready, bus32.out_imm, bus32.out_tag,
               bus32.out_illegal, err32);
    end
    step();
    reset = 1'b0;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bus32.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_stale_%0d: out_valid=%b tag=%0d want 0", i,
                 bus32.out_valid, bus32.out_tag);
      end
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_xlen64();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
